i2c_addr_translator: RTL and testbench

// - Inline I2C address translator between an upstream master bus (sd_m/sc_m) and a downstream target bus (sd_t/sc_t).
// - Responds to virtual 7-bit address `addr` and rewrites it on the fly to r_add = addr ^ XLATE_MASK.
// - Forwards the following data bytes and ACKs transparently; both buses are open-drain (drive 0 or z, external pullups).

---
 rtl/i2c_xlate_pkg.sv | 18 +
 rtl/i2c_bus_sampler.sv | 52 +++++
 rtl/i2c_addr_translator.sv | 197 +++++++++++++++++++
 tb/tb_i2c_addr_translator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_xlate_pkg.sv
// rtl/i2c_xlate_pkg.sv - shared types and defaults for the I2C address translator
package i2c_xlate_pkg;

  // Default XOR mask applied to the forwarded address bits.
  localparam logic [6:0] XLATE_MASK_DEFAULT = 7'h08;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_AACK  = 3'd2,
    ST_WDATA = 3'd3,
    ST_WACK  = 3'd4,
    ST_RDATA = 3'd5,
    ST_RACK  = 3'd6,
    ST_BLOCK = 3'd7
  } xlate_state_e;

endpackage

// File: rtl/i2c_bus_sampler.sv
// rtl/i2c_bus_sampler.sv - bus line synchroniser and START/STOP/edge pulse generator
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   scl, sda, sdt    raw master SCL, master SDA, target SDA
//   scl_q, scl_prev  current and previous SCL samples
//   sda_q, sdt_q     current master / target SDA samples
//   start, stop      START / STOP condition pulses on the master bus
//   rise, fall       SCL edge pulses
module i2c_bus_sampler (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  input  logic sdt,
  output logic scl_q,
  output logic scl_prev,
  output logic sda_q,
  output logic sdt_q,
  output logic start,
  output logic stop,
  output logic rise,
  output logic fall
);

  logic sda_prev;

  // Reset to the idle-high bus level so leaving reset on a quiet bus
  // produces no spurious edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q    <= 1'b1;
      scl_prev <= 1'b1;
      sda_q    <= 1'b1;
      sda_prev <= 1'b1;
      sdt_q    <= 1'b1;
    end else begin
      scl_prev <= scl_q;
      scl_q    <= scl;
      sda_prev <= sda_q;
      sda_q    <= sda;
      sdt_q    <= sdt;
    end
  end

  // SDA may only move with SCL high for START/STOP, so both SCL samples
  // must be high.
  assign start = scl_q & scl_prev & sda_prev & ~sda_q;
  assign stop  = scl_q & scl_prev & ~sda_prev & sda_q;
  assign rise  = scl_q & ~scl_prev;
  assign fall  = ~scl_q & scl_prev;

endmodule

// File: rtl/i2c_addr_translator.sv
// rtl/i2c_addr_translator.sv - inline I2C address translator (virtual addr -> addr ^ mask)
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   addr              virtual 7-bit address answered by this block
//   sd_m, sc_m        master-side SDA (open-drain inout) and SCL (input)
//   sd_t, sc_t        target-side SDA (open-drain inout) and SCL (open-drain out)
//   start, stop       START / STOP pulses
//   rising            SCL rising-edge pulse
//   counter           bit index within the current byte
//   add_reg           received {address, R/W}
//   RW_indicator      R/W bit of the matched transfer
//   match_indicator   received address equals addr
//   r_add             translated address
//   state             FSM state encoding
module i2c_addr_translator
  import i2c_xlate_pkg::*;
#(
  parameter logic [6:0] XLATE_MASK = XLATE_MASK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  inout  wire        sd_m,
  input  logic       sc_m,
  inout  wire        sd_t,
  output wire        sc_t,
  output logic       start,
  output logic       stop,
  output logic       rising,
  output logic [2:0] counter,
  output logic [7:0] add_reg,
  output logic       RW_indicator,
  output logic       match_indicator,
  output logic [6:0] r_add,
  output logic [2:0] state
);

  logic scl_q, scl_prev, sda_q, sdt_q, rise, fall;

  i2c_bus_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .scl      (sc_m),
    .sda      (sd_m),
    .sdt      (sd_t),
    .scl_q    (scl_q),
    .scl_prev (scl_prev),
    .sda_q    (sda_q),
    .sdt_q    (sdt_q),
    .start    (start),
    .stop     (stop),
    .rise     (rise),
    .fall     (fall)
  );

  xlate_state_e state_q, state_d;
  logic [2:0]   counter_q, counter_d;
  logic [7:0]   add_reg_q, add_reg_d;
  logic         match_q, match_d;
  logic         rw_q, rw_d;
  logic         full_q, full_d;       // eight bits clocked since entering the state
  logic         tgt_nack_q, tgt_nack_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      counter_q  <= 3'd0;
      add_reg_q  <= 8'h00;
      match_q    <= 1'b0;
      rw_q       <= 1'b0;
      full_q     <= 1'b0;
      tgt_nack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      add_reg_q  <= add_reg_d;
      match_q    <= match_d;
      rw_q       <= rw_d;
      full_q     <= full_d;
      tgt_nack_q <= tgt_nack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    add_reg_d  = add_reg_q;
    match_d    = match_q;
    rw_d       = rw_q;
    full_d     = full_q;
    tgt_nack_d = tgt_nack_q;

    if (rise) begin
      counter_d = counter_q + 3'd1;
      if (counter_q == 3'd7) full_d = 1'b1;
      if (state_q == ST_ADDR) add_reg_d = {add_reg_q[6:0], sda_q};
      if (state_q == ST_AACK) tgt_nack_d = sdt_q;
    end

    if (fall) begin
      case (state_q)
        ST_ADDR: begin
          if (full_q) begin
            match_d   = (add_reg_q[7:1] == addr);
            rw_d      = add_reg_q[0];
            state_d   = ST_AACK;
            counter_d = 3'd0;
            full_d    = 1'b0;
          end
        end
        ST_AACK: begin
          state_d   = (!match_q || tgt_nack_q) ? ST_BLOCK :
                      (rw_q ? ST_RDATA : ST_WDATA);
          counter_d = 3'd0;
          full_d    = 1'b0;
        end
        ST_WDATA: begin
          if (full_q) begin
            state_d   = ST_WACK;
            counter_d = 3'd0;
            full_d    = 1'b0;
          end
        end
        ST_WACK: begin
          state_d   = ST_WDATA;
          counter_d = 3'd0;
          full_d    = 1'b0;
        end
        ST_RDATA: begin
          if (full_q) begin
            state_d   = ST_RACK;
            counter_d = 3'd0;
            full_d    = 1'b0;
          end
        end
        ST_RACK: begin
          state_d   = ST_RDATA;
          counter_d = 3'd0;
          full_d    = 1'b0;
        end
        default: ;
      endcase
    end

    // Bus conditions override any bit-level progress.
    if (start) begin
      state_d   = ST_ADDR;
      counter_d = 3'd0;
      full_d    = 1'b0;
      match_d   = 1'b0;
      rw_d      = 1'b0;
    end else if (stop) begin
      state_d   = ST_IDLE;
      counter_d = 3'd0;
      full_d    = 1'b0;
    end
  end

  // The counter advances on SCL rise, so while the previous SCL sample is
  // high the bit on the wire is one behind the counter. Keying on scl_prev
  // also holds the XOR term for one clk after sc_t falls, giving the target
  // hold time before the address bit flips.
  logic [2:0] bit_idx;
  logic [7:0] xor_seq;
  assign bit_idx = scl_prev ? (counter_q - 3'd1) : counter_q;
  assign xor_seq = {XLATE_MASK, 1'b0};   // index 7-bit_idx; R/W slot passes through

  // Mirroring uses the registered samples, so neither bus feeds the other
  // combinationally and both SDA copies stay aligned with sc_t (= scl_q).
  logic sdm_low, sdt_low;
  always_comb begin
    sdm_low = 1'b0;
    sdt_low = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE, ST_WDATA, ST_RACK, ST_BLOCK: sdt_low = ~sda_q;
        ST_ADDR:          sdt_low = ~(sda_q ^ xor_seq[3'd7 - bit_idx]);
        ST_AACK:          sdm_low = match_q & ~sdt_q;
        ST_WACK, ST_RDATA: sdm_low = ~sdt_q;
        default: ;
      endcase
    end
  end

  assign sd_m = sdm_low ? 1'b0 : 1'bz;
  assign sd_t = sdt_low ? 1'b0 : 1'bz;
  assign sc_t = (rst && !scl_q) ? 1'b0 : 1'bz;

  assign rising          = rise;
  assign counter         = counter_q;
  assign add_reg         = add_reg_q;
  assign RW_indicator    = rw_q;
  assign match_indicator = match_q;
  assign r_add           = addr ^ XLATE_MASK;
  assign state           = state_q;

endmodule

// File: tb/tb_i2c_addr_translator.sv
// tb/tb_i2c_addr_translator.sv - self-checking bench for i2c_addr_translator
module tb_i2c_addr_translator;

  localparam logic [6:0] XM = 7'h08;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] addr;
  logic       sc_m;
  logic       m_sda_low, t_sda_low;
  wire        sd_m_w, sd_t_w, sc_t_w;

  pullup (sd_m_w);
  pullup (sd_t_w);
  pullup (sc_t_w);
  assign sd_m_w = m_sda_low ? 1'b0 : 1'bz;
  assign sd_t_w = t_sda_low ? 1'b0 : 1'bz;

  logic       start, stop, rising, RW_indicator, match_indicator;
  logic [2:0] counter, state;
  logic [7:0] add_reg;
  logic [6:0] r_add;

  i2c_addr_translator dut (
    .clk             (clk),
    .rst             (rst),
    .addr            (addr),
    .sd_m            (sd_m_w),
    .sc_m            (sc_m),
    .sd_t            (sd_t_w),
    .sc_t            (sc_t_w),
    .start           (start),
    .stop            (stop),
    .rising          (rising),
    .counter         (counter),
    .add_reg         (add_reg),
    .RW_indicator    (RW_indicator),
    .match_indicator (match_indicator),
    .r_add           (r_add),
    .state           (state)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rise = 0;

  // Pulse counters: a pulse wider than one clk counts more than once.
  always @(negedge clk) begin
    if (start)  n_start++;
    if (stop)   n_stop++;
    if (rising) n_rise++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // One SCL clock: set SDA in the low phase, sample both buses mid-high.
  task automatic bit_cycle(input logic mb, input logic tb_bit,
                           output logic ms, output logic ts, output logic [2:0] st);
    @(negedge clk);
    m_sda_low = ~mb;
    t_sda_low = ~tb_bit;
    repeat (5) @(negedge clk);
    sc_m = 1'b1;
    repeat (3) @(negedge clk);
    ms = sd_m_w;
    ts = sd_t_w;
    st = state;
    repeat (3) @(negedge clk);
    sc_m = 1'b0;
  endtask

  task automatic do_start;
    @(negedge clk);
    m_sda_low = 1'b0;
    t_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    sc_m = 1'b1;
    repeat (4) @(negedge clk);
    m_sda_low = 1'b1;
    repeat (4) @(negedge clk);
    sc_m = 1'b0;
  endtask

  task automatic do_stop;
    @(negedge clk);
    m_sda_low = 1'b1;
    t_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    sc_m = 1'b1;
    repeat (4) @(negedge clk);
    m_sda_low = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Master sends the top n bits of v, target released.
  task automatic send_bits(input logic [7:0] v, input int n);
    logic ms, ts;
    logic [2:0] st;
    for (int i = 7; i > 7 - n; i--) bit_cycle(v[i], 1'b1, ms, ts, st);
  endtask

  // Full transaction against the protocol model:
  // target sees {a^XM, rw}; master sees ACK only for a matching address the
  // target acknowledges; write bytes reach the target, read bytes the master.
  task automatic xfer(input logic [6:0] a, input logic rw, input logic tgt_ack,
                      input int nb, input logic [31:0] data);
    logic [7:0] abyte, seen, d;
    logic       ms, ts, exp_match, ok, mack;
    logic [2:0] st;
    logic       st_ok;
    int         s0, r0;
    abyte     = {a, rw};
    exp_match = (a == addr);
    s0 = n_start;
    do_start;
    checks++;
    if (n_start - s0 !== 1) begin errors++; $display("FAIL start_pulse got %0d want 1", n_start - s0); end
    r0 = n_rise;
    st_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(abyte[i], 1'b1, ms, ts, st);
      seen[i] = ts;
      if (st !== 3'd1) st_ok = 1'b0;
    end
    checks++;
    if (st_ok !== 1'b1) begin errors++; $display("FAIL addr_state got last %0d want 1", st); end
    checks++;
    if (seen !== {a ^ XM, rw}) begin errors++; $display("FAIL target_addr got %h want %h", seen, {a ^ XM, rw}); end
    checks++;
    if (n_rise - r0 !== 8) begin errors++; $display("FAIL rise_count got %0d want 8", n_rise - r0); end

    bit_cycle(1'b1, ~tgt_ack, ms, ts, st);
    checks++;
    if (st !== 3'd2) begin errors++; $display("FAIL aack_state got %0d want 2", st); end
    checks++;
    if (add_reg !== abyte) begin errors++; $display("FAIL add_reg got %h want %h", add_reg, abyte); end
    checks++;
    if (match_indicator !== exp_match) begin errors++; $display("FAIL match got %b want %b", match_indicator, exp_match); end
    checks++;
    if (RW_indicator !== rw) begin errors++; $display("FAIL rw got %b want %b", RW_indicator, rw); end
    checks++;
    if (ms !== ~(exp_match & tgt_ack)) begin errors++; $display("FAIL master_ack got %b want %b", ms, ~(exp_match & tgt_ack)); end

    ok = exp_match & tgt_ack;
    if (!ok) begin
      bit_cycle(1'($urandom_range(0, 1)), 1'b1, ms, ts, st);
      checks++;
      if (st !== 3'd7) begin errors++; $display("FAIL block_state got %0d want 7", st); end
    end else begin
      for (int b = 0; b < nb; b++) begin
        d = data[8*b +: 8];
        st_ok = 1'b1;
        for (int i = 7; i >= 0; i--) begin
          if (!rw) begin
            bit_cycle(d[i], 1'b1, ms, ts, st);
            seen[i] = ts;
            if (st !== 3'd3) st_ok = 1'b0;
          end else begin
            bit_cycle(1'b1, d[i], ms, ts, st);
            seen[i] = ms;
            if (st !== 3'd5) st_ok = 1'b0;
          end
        end
        checks++;
        if (seen !== d) begin errors++; $display("FAIL data_byte%0d got %h want %h", b, seen, d); end
        checks++;
        if (st_ok !== 1'b1) begin errors++; $display("FAIL data_state got last %0d want %0d", st, rw ? 5 : 3); end
        if (!rw) begin
          bit_cycle(1'b1, 1'b0, ms, ts, st);
          checks++;
          if (ms !== 1'b0 || st !== 3'd4) begin errors++; $display("FAIL wack got sda %b st %0d want 0 st 4", ms, st); end
        end else begin
          mack = (b == nb - 1);
          bit_cycle(mack, 1'b1, ms, ts, st);
          checks++;
          if (ts !== mack || st !== 3'd6) begin errors++; $display("FAIL rack got sda %b st %0d want %b st 6", ts, st, mack); end
        end
      end
    end

    s0 = n_stop;
    do_stop;
    checks++;
    if (n_stop - s0 !== 1 || state !== 3'd0 || counter !== 3'd0) begin
      errors++;
      $display("FAIL stop_end got pulses %0d st %0d cnt %0d want 1 0 0", n_stop - s0, state, counter);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd0 || counter !== 3'd0 || add_reg !== 8'h00) begin
      errors++; $display("FAIL reset_regs got st %0d cnt %0d add %h want 0 0 00", state, counter, add_reg);
    end
    checks++;
    if ({start, stop, rising, RW_indicator, match_indicator} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {start, stop, rising, RW_indicator, match_indicator});
    end
    checks++;
    if (sd_t_w !== 1'b1 || sc_t_w !== 1'b1) begin
      errors++; $display("FAIL reset_lines got sd_t %b sc_t %b want 1 1", sd_t_w, sc_t_w);
    end
    checks++;
    if (r_add !== (addr ^ XM)) begin errors++; $display("FAIL r_add got %h want %h", r_add, addr ^ XM); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;    xfer(7'h49, 1'b0, 1'b1, 1, 32'h3C); endtask
  task automatic test_no_match; xfer(7'h48, 1'b0, 1'b1, 1, 32'h00); endtask
  task automatic test_read;     xfer(7'h49, 1'b1, 1'b1, 1, 32'hA5); endtask

  task automatic test_stop_restart;
    logic ms, ts;
    logic [2:0] st;
    int s0;
    do_start;
    send_bits(8'h92, 8);
    bit_cycle(1'b1, 1'b0, ms, ts, st);
    send_bits(8'hA0, 3);
    checks++;
    if (state !== 3'd3 || counter !== 3'd3) begin
      errors++; $display("FAIL midbyte got st %0d cnt %0d want 3 3", state, counter);
    end
    s0 = n_stop;
    do_stop;
    checks++;
    if (n_stop - s0 !== 1 || state !== 3'd0 || counter !== 3'd0) begin
      errors++; $display("FAIL mid_stop got pulses %0d st %0d cnt %0d want 1 0 0", n_stop - s0, state, counter);
    end
    s0 = n_start;
    do_start;
    checks++;
    if (n_start - s0 !== 1 || state !== 3'd1) begin
      errors++; $display("FAIL start_after_stop got pulses %0d st %0d want 1 1", n_start - s0, state);
    end
    send_bits(8'h92, 8);
    bit_cycle(1'b1, 1'b0, ms, ts, st);
    send_bits(8'h40, 2);
    s0 = n_start;
    do_start;
    checks++;
    if (n_start - s0 !== 1 || state !== 3'd1 || counter !== 3'd0) begin
      errors++; $display("FAIL rep_start got pulses %0d st %0d cnt %0d want 1 1 0", n_start - s0, state, counter);
    end
    do_stop;
  endtask

  task automatic test_reset_mid_addr;
    do_start;
    send_bits(8'h92, 3);
    @(negedge clk);
    m_sda_low = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sc_t_w !== 1'b0 || state !== 3'd1) begin
      errors++; $display("FAIL pre_reset got sc_t %b st %0d want 0 1", sc_t_w, state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || counter !== 3'd0 || sc_t_w !== 1'b1 || sd_t_w !== 1'b1) begin
      errors++; $display("FAIL mid_reset got st %0d cnt %0d sc_t %b sd_t %b want 0 0 1 1", state, counter, sc_t_w, sd_t_w);
    end
    rst = 1'b1;
    m_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    sc_m = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL post_reset got st %0d want 0", state); end
  endtask

  task automatic test_random;
    logic [6:0] a;
    for (int n = 0; n < 8; n++) begin
      addr = 7'($urandom);
      @(negedge clk);
      checks++;
      if (r_add !== (addr ^ XM)) begin errors++; $display("FAIL rand_r_add got %h want %h", r_add, addr ^ XM); end
      a = ($urandom_range(0, 2) != 0) ? addr : (addr ^ 7'($urandom_range(1, 127)));
      xfer(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
           int'($urandom_range(1, 3)), $urandom);
    end
  endtask

  initial begin
    rst       = 1'b0;
    addr      = 7'h49;
    sc_m      = 1'b1;
    m_sda_low = 1'b0;
    t_sda_low = 1'b0;
    test_reset;
    test_write;
    test_no_match;
    test_read;
    test_stop_restart;
    test_reset_mid_addr;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
